tlc_cfg_sequencer: RTL
======================

// Module: tlc_cfg_sequencer
// PURPOSE
//   Upstream config stage for the tlc controller. Accepts a complete light-timing set (red/yellow/green delays, in seconds).
//   Buffers each set in a small FIFO. Serialises every set into three register writes on the tlc addr/data/valid/ready port.
//   Order is red, yellow, green. Lets software/host logic post new timings at any time without driving the tlc protocol itself.
// PARAMETERS
//   ADDR_WIDTH   3  width of addr to tlc
//   DATA_WIDTH   8  width of each delay field and of data to tlc
//   ADDR_RED     0  tlc register address of red delay
//   ADDR_YELLOW  1  tlc register address of yellow delay
//   ADDR_GREEN   2  tlc register address of green delay
//   DEPTH        2  timing sets buffered; power of 2, >=2
// PORTS
//   clk        in   1               system clock
//   rst        in   1               synchronous, active-high reset
//   cfg_valid  in   1               timing set offered
//   cfg_ready  out  1               set accepted when cfg_valid&&cfg_ready at posedge
//   cfg_red    in   DATA_WIDTH      red delay
//   cfg_yellow in   DATA_WIDTH      yellow delay
//   cfg_green  in   DATA_WIDTH      green delay
//   addr       out  ADDR_WIDTH      tlc register address
//   data       out  DATA_WIDTH      tlc register data
//   valid      out  1               write request to tlc
//   ready      in   1               tlc accepts write when valid&&ready at posedge
//   pending    out  $clog2(DEPTH)+1 sets in FIFO, including one being written
// BEHAVIOUR
// - Reset (one posedge with rst=1): FIFO emptied, FSM->IDLE; valid=0, addr=0, data=0, pending=0.
//   cfg_ready=1 from the first cycle after reset. Inputs during rst are ignored.
// - cfg_ready = !full. No push-through when full, even if a pop occurs in the same cycle.
// - FSM states IDLE, WR_RED, WR_YELLOW, WR_GREEN; state is registered.
//   valid=(state!=IDLE). addr/data decode from state and the FIFO head entry.
//   IDLE drives addr=0 and data=0.
// - IDLE -> WR_RED on the posedge where FIFO is non-empty, including a set pushed at that same edge.
//   Latency: set accepted at edge N -> valid=1 with addr=ADDR_RED during cycle N+1.
// - WR_RED->WR_YELLOW->WR_GREEN, each advancing only on valid&&ready.
//   While ready=0, addr/data/valid stay stable (no retraction, no change).
// - WR_GREEN on valid&&ready: pop head; pending decrements.
//   FIFO still non-empty after pop -> WR_RED directly, no idle bubble; else -> IDLE.
// - Simultaneous push and pop in one cycle: pending unchanged; both take effect.
// - FIFO pointers wrap modulo DEPTH. Head entry is never modified while being written.
// - Reset mid-sequence aborts immediately. Writes already accepted by tlc stand (partial update allowed).
//   Resetting tlc is the system's responsibility.
// - Fields are passed unmodified unless the clamp feature is enabled.
// CONFIGURATION
//   TLC_CFG_CLAMP_EN defined: any zero delay field is replaced by 1 when pushed into the FIFO.
//     tlc never receives a 0-second delay.
//   TLC_CFG_CLAMP_EN undefined: fields are stored and written verbatim, 0 included.
//   Ports, latency and handshake are identical either way.
// TESTING
// 1. rst=1 for 4 cycles, then 0 -> valid=0, addr=0, data=0, pending=0, cfg_ready=1.
// 2. Push (3,1,5) with ready=1 -> cycles N+1..N+3: valid=1, addr=0/1/2, data=3/1/5.
//    Then valid=0 and pending=0.
// 3. Push (4,2,7); hold ready=0 for 2 cycles while addr=1 -> addr=1 and data=2 held.
//    valid high for 5 cycles total; green=7 written last.
// 4. ready=0; push (3,1,5), (4,2,7), (9,9,9) -> first two accepted, pending=2, cfg_ready=0, third not accepted.
//    Then ready=1 -> 6 consecutive writes 3,1,5,4,2,7 with no gap.
// 5. Push (3,1,5); assert rst right after the red write is accepted -> next cycle valid=0, pending=0, cfg_ready=1.
//    No yellow/green write issued.
// 6. Push (0,2,0) -> with TLC_CFG_CLAMP_EN data=1,2,1; without it data=0,2,0.

Source files
------------

// File: rtl/tlc_cfg_sequencer.sv
// tlc_cfg_sequencer
//   Buffers complete light-timing sets (red/yellow/green delays) in a small
//   FIFO and serialises each set into three tlc register writes, in the order
//   red, yellow, green, over an addr/data/valid/ready port.
//
// Ports
//   clk, rst                   clock; synchronous active-high reset
//   cfg_valid/cfg_ready        timing-set handshake (cfg_ready = FIFO not full)
//   cfg_red/yellow/green       delay fields of the offered set
//   addr/data/valid/ready      tlc register-write handshake
//   pending                    sets held in the FIFO, including the one in flight
//
// Configuration
//   TLC_CFG_CLAMP_EN  when defined, zero delay fields are stored as 1 so the
//                     tlc never receives a 0-second delay. Ports, latency and
//                     handshake are the same either way.
module tlc_cfg_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_RED    = 0,
  parameter int unsigned ADDR_YELLOW = 1,
  parameter int unsigned ADDR_GREEN  = 2,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [DATA_WIDTH-1:0]      cfg_red,
  input  logic [DATA_WIDTH-1:0]      cfg_yellow,
  input  logic [DATA_WIDTH-1:0]      cfg_green,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic [DATA_WIDTH-1:0]      data,
  output logic                       valid,
  input  logic                       ready,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 3 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, WR_RED, WR_YELLOW, WR_GREEN} state_t;

  state_t                 state, state_nxt;
  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   full_c, push_c, pop_c;
  logic [ENTRY_W-1:0]     head_c;
  logic [DATA_WIDTH-1:0]  head_red_c, head_yellow_c, head_green_c;

  // Field conditioning applied on the way into the FIFO.
  function automatic logic [DATA_WIDTH-1:0] cond_field(input logic [DATA_WIDTH-1:0] v);
`ifdef TLC_CFG_CLAMP_EN
    return (v == '0) ? DATA_WIDTH'(1) : v;
`else
    return v;
`endif
  endfunction

  assign full_c    = (count == CNT_W'(DEPTH));
  assign cfg_ready = !full_c;
  // Acceptance depends only on the registered fill level, never on a same-cycle pop.
  assign push_c    = cfg_valid && !full_c;
  assign pop_c     = (state == WR_GREEN) && ready;
  assign pending   = count;

  assign head_c        = mem[rd_ptr];
  assign head_red_c    = head_c[ENTRY_W-1 -: DATA_WIDTH];
  assign head_yellow_c = head_c[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign head_green_c  = head_c[DATA_WIDTH-1:0];

  // FIFO storage; stale contents after reset are unreachable via the pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= {cond_field(cfg_red), cond_field(cfg_yellow), cond_field(cfg_green)};
    end
  end

  // FIFO pointers and fill level; power-of-two DEPTH makes pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and write-port decode.
  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    addr      = '0;
    data      = '0;
    case (state)
      IDLE: begin
        // A set pushed at this edge starts immediately.
        if ((count != '0) || push_c) state_nxt = WR_RED;
      end
      WR_RED: begin
        valid = 1'b1;
        addr  = ADDR_WIDTH'(ADDR_RED);
        data  = head_red_c;
        if (ready) state_nxt = WR_YELLOW;
      end
      WR_YELLOW: begin
        valid = 1'b1;
        addr  = ADDR_WIDTH'(ADDR_YELLOW);
        data  = head_yellow_c;
        if (ready) state_nxt = WR_GREEN;
      end
      WR_GREEN: begin
        valid = 1'b1;
        addr  = ADDR_WIDTH'(ADDR_GREEN);
        data  = head_green_c;
        // Back-to-back sets chain straight into the next red write.
        if (ready) state_nxt = ((count > CNT_W'(1)) || push_c) ? WR_RED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
